edge_count_divider: RTL

EDGE_COUNT_DIVIDER -- requirements
Module: edge_count_divider

---
 rtl/edge_count_divider_pkg.sv | 9 +
 rtl/edge_count_divider_rise_detect.sv | 23 ++
 rtl/edge_count_divider.sv | 46 ++++
 3 files changed

// File: rtl/edge_count_divider_pkg.sv
// Shared constants for the edge-counting divider.
package edge_count_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Level that the delayed din register takes in reset, so held-high din is not an edge.
  localparam logic DIN_D_RESET = 1'b1;

endpackage : edge_count_divider_pkg

// File: rtl/edge_count_divider_rise_detect.sv
// Rising-edge detector: registers din every clock and flags din & ~din_d.
module rise_detect
  import edge_count_divider_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      din_d <= DIN_D_RESET;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule : rise_detect

// File: rtl/edge_count_divider.sv
// Counts qualified din rising edges; wraps after div+1 edges with a tick pulse and q toggle.
module edge_count_divider
  import edge_count_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             din,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             q
);

  logic rise;

  rise_detect u_rise_detect (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (din),
    .rise    (rise)
  );

  // The >= compare wraps even when div drops below count, so count+1 never overflows.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      tick  <= 1'b0;
      q     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (rise && enable) begin
        if (count >= div) begin
          count <= '0;
          tick  <= 1'b1;
          q     <= ~q;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule : edge_count_divider
